uart_cmd_rx: RTL and testbench

Serial command front end for the tetris game. Receives 8N1 UART bytes on `uart_rx`, maps printable keys to 3-bit game commands, and buffers them in a 4-entry show-ahead FIFO. The FIFO drains into the game control logic through a valid/ready handshake. Sits directly upstream of the control block, on the same 50 MHz clock.

---
 rtl/uart_cmd_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with key-to-command decode and a 4-entry
// show-ahead command FIFO feeding the tetris control block over valid/ready.
module uart_cmd_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_stb,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       overflow,
  output logic [7:0] frame_err_cnt
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } rx_state_t;

  // Synchronizer and edge-detect history
  logic rx_meta;
  logic rxs;
  logic rxs_prev;

  // Receiver state
  rx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  // Decode and FIFO
  logic [2:0] dec_code;
  logic [2:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;
  logic       full;
  logic       push_ok;

  // Bring the asynchronous line into the clock domain; flops idle high so
  // reset release never looks like a start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= uart_rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // Receive FSM: mid-bit sampling, stop-bit framing check, registered strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      rx_byte       <= '0;
      rx_stb        <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      rx_stb <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rxs_prev && !rxs) begin
            baud_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == CNT_HALF) begin
            baud_cnt <= '0;
            if (!rxs) begin
              bit_idx <= '0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rxs, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (rxs) begin
              rx_byte <= shift_reg;
              rx_stb  <= 1'b1;
              state   <= S_IDLE;
            end else begin
              if (frame_err_cnt != 8'hFF) begin
                frame_err_cnt <= frame_err_cnt + 1'b1;
              end
              state <= S_WAIT_HI;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_WAIT_HI: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Map printable keys to game commands; 0 means "not a command".
  // NOTE: the default assignment before the case keeps this purely
  // combinational; without it unmatched bytes would infer a latch.
  always_comb begin
    dec_code = 3'd0;
    case (rx_byte)
      8'h61, 8'h41: dec_code = 3'd1;  // a/A  LEFT
      8'h64, 8'h44: dec_code = 3'd2;  // d/D  RIGHT
      8'h73, 8'h53: dec_code = 3'd3;  // s/S  DOWN
      8'h77, 8'h57: dec_code = 3'd4;  // w/W  ROTATE
      8'h20:        dec_code = 3'd5;  // ' '  DROP
      8'h63, 8'h43: dec_code = 3'd6;  // c/C  HOLD
      8'h70, 8'h50: dec_code = 3'd7;  // p/P  PAUSE
      default:      dec_code = 3'd0;
    endcase
  end

  assign push    = rx_stb && (dec_code != 3'd0);
  assign pop     = cmd_valid && cmd_ready;
  assign full    = (count == 3'd4);
  // When full, a simultaneous pop frees the slot the write lands in.
  assign push_ok = push && (!full || pop);

  // Command FIFO: show-ahead, pointers wrap naturally at 2 bits.
  // NOTE: the storage is reset too; it is only 12 bits and cmd must read 0
  // out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 3'd0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= dec_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign cmd_valid = (count != 3'd0);
  assign cmd       = mem[rd_ptr];

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed bench for uart_cmd_rx with byte/command scoreboards.
module tb_uart_cmd_rx;

  // Slower clock keeps the 115200 line rate but shortens each bit to 48 cycles.
  localparam int CLK_HZ = 5_529_600;
  localparam int BAUD   = 115200;
  localparam int CPB    = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_byte;
  logic       rx_stb;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       overflow;
  logic [7:0] frame_err_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes [$];
  logic [2:0] exp_cmds  [$];
  logic       exp_overflow = 1'b0;

  int stb_seen     = 0;
  int valid_cycles = 0;
  int pops         = 0;
  logic prev_stb   = 1'b0;

  uart_cmd_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .rx_byte      (rx_byte),
    .rx_stb       (rx_stb),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .overflow     (overflow),
    .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] key_code(input logic [7:0] b);
    logic [2:0] c;
    c = 3'd0;
    case (b)
      "a", "A": c = 3'd1;
      "d", "D": c = 3'd2;
      "s", "S": c = 3'd3;
      "w", "W": c = 3'd4;
      " ":      c = 3'd5;
      "c", "C": c = 3'd6;
      "p", "P": c = 3'd7;
      default:  c = 3'd0;
    endcase
    return c;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame and record what the DUT should produce for it.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [2:0] c;
    if (stop_bit) begin
      exp_bytes.push_back(b);
      c = key_code(b);
      if (c != 3'd0) begin
        if (exp_cmds.size() < 4) exp_cmds.push_back(c);
        else                     exp_overflow = 1'b1;
      end
    end
    uart_rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cycles(CPB);
    end
    uart_rx = stop_bit;
    cycles(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic drain(input int budget);
    cmd_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (exp_cmds.size() == 0) break;
      cycles(1);
    end
    cmd_ready = 1'b0;
    check("drain_done", exp_cmds.size(), 0);
  endtask

  // Scoreboard monitor, sampled on the falling edge away from updates.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_stb) begin
        stb_seen++;
        check("rx_stb_width", prev_stb, 1'b0);
        check("rx_stb_expected", exp_bytes.size() != 0, 1'b1);
        if (exp_bytes.size() != 0) check("rx_byte", rx_byte, exp_bytes.pop_front());
      end
      if (cmd_valid) valid_cycles++;
      if (cmd_valid && cmd_ready) begin
        pops++;
        check("pop_expected", exp_cmds.size() != 0, 1'b1);
        if (exp_cmds.size() != 0) check("cmd", cmd, exp_cmds.pop_front());
      end
      prev_stb = rx_stb;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int stb0;
    int vc0;
    int pops0;
    string s;

    reset     = 1'b1;
    uart_rx   = 1'b1;
    cmd_ready = 1'b0;
    cycles(3);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_stb", rx_stb, 1'b0);
    check("rst_cmd", cmd, 3'd0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err_cnt, 8'd0);
    reset = 1'b0;
    cycles(2 * CPB);

    // Single 'a' held in the FIFO, then popped with a 1-cycle ready.
    stb0 = stb_seen;
    send_byte(8'h61, 1'b1);
    cycles(5);
    check("a_stb_count", stb_seen - stb0, 1);
    check("a_rx_byte", rx_byte, 8'h61);
    check("a_valid", cmd_valid, 1'b1);
    check("a_cmd", cmd, 3'd1);
    cycles(20);
    check("a_valid_hold", cmd_valid, 1'b1);
    check("a_cmd_hold", cmd, 3'd1);
    cmd_ready = 1'b1;
    cycles(1);
    cmd_ready = 1'b0;
    check("a_valid_after_pop", cmd_valid, 1'b0);

    // Back-to-back "wW xP" with ready held high.
    stb0  = stb_seen;
    vc0   = valid_cycles;
    pops0 = pops;
    cmd_ready = 1'b1;
    s = "wW xP";
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    cycles(5);
    cmd_ready = 1'b0;
    check("b2b_stb_count", stb_seen - stb0, 5);
    check("b2b_pops", pops - pops0, 4);
    check("b2b_valid_cycles", valid_cycles - vc0, 4);
    check("b2b_sb_empty", exp_cmds.size(), 0);

    // "asdcw" with ready low: the fifth command overflows.
    s = "asdcw";
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    cycles(5);
    check("ovf_flag", overflow, exp_overflow);
    check("ovf_valid", cmd_valid, 1'b1);
    check("ovf_head", cmd, 3'd1);
    drain(50);
    cycles(1);
    check("ovf_empty_after_drain", cmd_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Framing error, line held high, then a good 'd'.
    stb0 = stb_seen;
    send_byte(8'h77, 1'b0);
    cycles(2 * CPB);
    check("ferr_count", frame_err_cnt, 8'd1);
    check("ferr_no_stb", stb_seen - stb0, 0);
    check("ferr_no_cmd", cmd_valid, 1'b0);
    send_byte(8'h64, 1'b1);
    cycles(5);
    check("ferr_d_valid", cmd_valid, 1'b1);
    check("ferr_d_cmd", cmd, 3'd2);
    drain(10);

    // Short low glitch on an idle line is rejected at the start-bit sample.
    stb0 = stb_seen;
    uart_rx = 1'b0;
    cycles(12);
    uart_rx = 1'b1;
    cycles(3 * CPB);
    check("glitch_no_stb", stb_seen - stb0, 0);
    check("glitch_ferr", frame_err_cnt, 8'd1);
    check("glitch_no_cmd", cmd_valid, 1'b0);

    // Reset during data bit 4 of 's', then a clean 'a'.
    check("pre_reset_sb_empty", exp_cmds.size() + exp_bytes.size(), 0);
    stb0 = stb_seen;
    uart_rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = 8'h73 >> i;
      cycles(CPB);
    end
    uart_rx = 1'b1;           // bit 4 of 0x73
    cycles(CPB / 2);
    reset = 1'b1;
    exp_overflow = 1'b0;
    cycles(1);
    reset = 1'b0;
    cycles(3 * CPB);
    check("rst_abort_no_stb", stb_seen - stb0, 0);
    check("rst_abort_valid", cmd_valid, 1'b0);
    check("rst_abort_ferr", frame_err_cnt, 8'd0);
    check("rst_abort_ovf", overflow, 1'b0);
    send_byte(8'h61, 1'b1);
    cycles(5);
    check("post_rst_stb", stb_seen - stb0, 1);
    check("post_rst_valid", cmd_valid, 1'b1);
    check("post_rst_cmd", cmd, 3'd1);
    drain(10);
    cycles(1);
    check("post_rst_empty", cmd_valid, 1'b0);
    check("final_byte_sb_empty", exp_bytes.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
